// File: rtl/uart_rx_fifo.sv
// UART receiver sampling each bit at its midpoint, feeding a first-word-fall-through
// queue whose entries carry per-frame stop-bit and parity error flags.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 106,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            rx,
    output logic [DATA_BITS-1:0]            rd_data,
    output logic                            rd_frame_err,
    output logic                            rd_parity_err,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun,
    input  logic                            clr_overrun,
    output logic                            busy
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [TW-1:0] HALF_M1   = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q, rx_prev_q;
    logic [TW-1:0]          timer_q, timer_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   wr_en_q, wr_en_d;
    logic [EW-1:0]          wr_entry_q, wr_entry_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   tick, last_data, last_stop, stop_err;
    logic                   pop, wr_accept;
    logic [EW-1:0]          head;

    assign tick      = (timer_q == '0);
    assign last_data = (bit_cnt_q == DATA_LAST);
    assign last_stop = (bit_cnt_q == STOP_LAST);
    assign stop_err  = ferr_q | ~rx_s_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (rx_prev_q && !rx_s_q) state_d = S_START;
            S_START:     if (tick) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:      if (tick && last_data) state_d = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:       if (tick) state_d = S_STOP;
            S_STOP:      if (tick && last_stop) state_d = stop_err ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Idle keeps the timer preloaded with the half-bit count so START lands mid start bit.
    always_comb begin
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        wr_en_d    = 1'b0;
        wr_entry_d = wr_entry_q;
        if (state_q == S_IDLE || state_q == S_WAIT_HIGH) begin
            timer_d   = HALF_M1;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
        end else if (!tick) begin
            timer_d = timer_q - 1'b1;
        end else begin
            timer_d = FULL_M1;
            case (state_q)
                S_DATA: begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
                end
                S_PAR: perr_d = (PARITY == 1) ? ~(^shift_q ^ rx_s_q) : (^shift_q ^ rx_s_q);
                S_STOP: begin
                    ferr_d    = stop_err;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_stop) begin
                        wr_en_d    = 1'b1;
                        wr_entry_d = {stop_err, perr_q, shift_q};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_entry_q <= '0;
        end else begin
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            wr_en_q    <= wr_en_d;
            wr_entry_q <= wr_entry_d;
        end
    end

    // A full queue still accepts a frame when the head leaves in the same cycle.
    always_comb begin
        pop       = rd_valid & rd_ready;
        wr_accept = wr_en_q & ((count_q < DEPTH_C) | pop);
        wr_ptr_d  = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overrun_d = (wr_en_q & ~wr_accept) ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_entry_q;
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        rd_valid      = (count_q != '0);
        rd_data       = rd_valid ? head[DATA_BITS-1:0] : '0;
        rd_parity_err = rd_valid & head[EW-2];
        rd_frame_err  = rd_valid & head[EW-1];
        fifo_count    = count_q;
        overrun       = overrun_q;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised synthesizable UART receiver with a buffered output queue. Generalises the bench-side serial sampler: configurable bit period, data width, parity and stop bits, plus glitch rejection, framing/parity error tagging and FIFO overrun detection. Sits between the board RX pin (RsRx) and the SoC bus or a bench checker, which drains it through a valid/ready port.

Parameters:
CLK_DIV, 106, clock cycles per bit (≥4); half-bit point = CLK_DIV/2 (integer division)
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, entries, power of two ≥2

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
rd_data  out  DATA_BITS  head entry data
rd_frame_err  out  1  head entry stop-bit error
rd_parity_err  out  1  head entry parity error
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer pops head when rd_valid & rd_ready
fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
overrun  out  1  sticky: frame dropped because FIFO full
clr_overrun  in  1  synchronous clear of overrun
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, resetn=0): FSM=IDLE, 2-flop rx synchroniser = 1, bit counter = 0, FIFO pointers and count = 0, overrun = 0; outputs rd_valid=0, busy=0, fifo_count=0, rd_data/rd_*_err = 0. Reset mid-frame discards the partial frame; FIFO contents are lost.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on rx_s falling edge (previous 1, current 0) → START and load timer = CLK_DIV/2 − 1.
- START: on timer expiry, sample rx_s. If 1 (glitch) → IDLE, no entry. If 0 → DATA, timer = CLK_DIV − 1.
- DATA: sample rx_s at each timer expiry into shift register, LSB first, DATA_BITS samples. Then → PARITY if PARITY≠0, else → STOP. Timer reloads CLK_DIV − 1 on every sample.
- PARITY: one sample. Odd: error if XOR(data, pbit) = 0. Even: error if XOR(data, pbit) = 1.
- STOP: STOP_BITS samples. frame_err = 1 if any stop sample = 0.
- On the final stop sample edge the entry {frame_err, parity_err, data} is formed; it is written on the next clock edge, and rd_valid is high from that edge on. FSM returns to IDLE on the final stop sample if frame_err = 0 (next start bit may follow immediately), else → WAIT_HIGH.
- WAIT_HIGH: stays until rx_s = 1, then → IDLE. A line break produces exactly one entry (frame_err = 1, data = 0).
- Bit sample times relative to the first rx_s = 0 cycle: start at CLK_DIV/2; data bit i at CLK_DIV/2 + (i+1)·CLK_DIV.
- FIFO: first-word-fall-through, head presented on rd_*. Pop when rd_valid & rd_ready.
- Write accepted if count < FIFO_DEPTH or a pop occurs in the same cycle (count unchanged). Otherwise the frame is dropped, overrun is set, and existing entries are untouched.
- Pointers wrap modulo FIFO_DEPTH. A pop with rd_valid = 0 is ignored.
- Overrun: set-priority. If the set condition and clr_overrun coincide, overrun stays 1.
- busy = (state ≠ IDLE).

Test Plan:
- 8N1, CLK_DIV=106: send 0x55 → one entry, rd_data=0x55, both error flags 0, fifo_count=1; pop with rd_ready → rd_valid=0, fifo_count=0.
- PARITY=2: send 0xA3 with parity bit 1 (correct bit is 0) → rd_parity_err=1, rd_data=0xA3. Send 0xA3 with parity bit 0 → rd_parity_err=0.
- Hold rx low for 2000 cycles, then release → exactly one entry, data=0x00, rd_frame_err=1; busy stays 1 until rx high; no second entry.
- rx low pulse of 20 cycles → no entry, busy returns to 0 after ~CLK_DIV/2 cycles, fifo_count=0.
- Send 17 frames 0x01..0x11 with rd_ready=0 → fifo_count=16, overrun=1, head=0x01. Pulse clr_overrun → overrun=0. Pop all 16 → 0x01..0x10 in order.
- Assert resetn=0 mid-DATA of a frame with 3 entries queued → immediately rd_valid=0, fifo_count=0, busy=0. After release, send 0x7E → single entry 0x7E with no errors.
- STOP_BITS=2, DATA_BITS=7: back-to-back frames 0x41, 0x42 with zero idle time → two entries in order, no errors.
